// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared opcodes, branch codes, fetch FSM states and immediate helpers
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'd51;
    localparam logic [6:0] OP_LOAD   = 7'd3;
    localparam logic [6:0] OP_IMM    = 7'd19;
    localparam logic [6:0] OP_BRANCH = 7'd99;
    localparam logic [6:0] OP_JAL    = 7'd111;
    localparam logic [6:0] OP_STORE  = 7'd35;
    localparam logic [6:0] OP_LUI    = 7'd55;

    localparam logic [2:0] TB_NONE = 3'd0;
    localparam logic [2:0] TB_BEQ  = 3'd1;
    localparam logic [2:0] TB_BNE  = 3'd2;
    localparam logic [2:0] TB_BLT  = 3'd3;
    localparam logic [2:0] TB_BGE  = 3'd4;
    localparam logic [2:0] TB_RSVD = 3'd5;
    localparam logic [2:0] TB_JAL  = 3'd6;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_ERRO  = 2'd2
    } state_t;

    function automatic logic [31:0] imm_b(input logic [31:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/decisao_desvio.sv
// rtl/decisao_desvio.sv - branch/jump decision and next-PC computation (combinational)
module decisao_desvio
    import riscv_pkg::*;
(
    input  logic        PCSrc,
    input  logic [2:0]  Tipo_Branch,
    input  logic        zero,
    input  logic        neg,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        taken,
    output logic [31:0] next_pc
);

    logic cond;
    logic unused_opcode_bits;

    // The low opcode bits never feed an immediate.
    assign unused_opcode_bits = ^instr[6:0];

    always_comb begin
        cond = 1'b0;
        case (Tipo_Branch)
            TB_BEQ:  cond = zero;
            TB_BNE:  cond = ~zero;
            TB_BLT:  cond = neg;
            TB_BGE:  cond = ~neg;
            TB_JAL:  cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

    assign taken = PCSrc & cond;

    always_comb begin
        next_pc = pc + 32'd4;
        if (taken) begin
            if (Tipo_Branch == TB_JAL) begin
                next_pc = pc + imm_j(instr);
            end else begin
                next_pc = pc + imm_b(instr);
            end
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch stage: fetch FSM, PC and instruction register
module busca_instrucao
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    input  logic        stall,
    input  logic        PCSrc,
    input  logic [2:0]  Tipo_Branch,
    input  logic        zero,
    input  logic        neg,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic [2:0]  f3,
    output logic [6:0]  f7,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        erro
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        erro_q, erro_d;
    logic [31:0] next_pc;
    logic        taken_unused;

    decisao_desvio u_decisao_desvio (
        .PCSrc       (PCSrc),
        .Tipo_Branch (Tipo_Branch),
        .zero        (zero),
        .neg         (neg),
        .instr       (instr_q),
        .pc          (pc_q),
        .taken       (taken_unused),
        .next_pc     (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        erro_d  = erro_q;
        case (state_q)
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!stall) begin
                    // A misaligned target traps without committing the PC.
                    if (next_pc[1:0] != 2'b00) begin
                        erro_d  = 1'b1;
                        state_d = ST_ERRO;
                    end else begin
                        pc_d    = next_pc;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_ERRO: begin
                state_d = ST_ERRO;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= NOP;
            erro_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            erro_q  <= erro_d;
        end
    end

    assign imem_req    = (state_q == ST_FETCH) & ~rst;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = instr_q[6:0];
    assign f3          = instr_q[14:12];
    assign f7          = instr_q[31:25];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign instr_valid = (state_q == ST_EXEC);
    assign erro        = erro_q;

endmodule
